// File: rtl/prog_counter.sv
// Program-counter sequencer: IDLE/RUN/HALTED control, BNE branch-target table,
// and an optional saturating RUN-cycle counter enabled by `define CYCLE_CNT_EN.
module prog_counter #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned LUT_IDX_W = 4
`ifdef CYCLE_CNT_EN
 ,parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Halt,
  input  logic                 BranchEn,
  input  logic                 AluZero,
  input  logic [LUT_IDX_W-1:0] LutIdx,
  input  logic                 LutWe,
  input  logic [LUT_IDX_W-1:0] LutWaddr,
  input  logic [PC_W-1:0]      LutWdata,
  output logic [PC_W-1:0]      PC,
  output logic                 Running,
  output logic                 Done,
  output logic                 BranchTaken
`ifdef CYCLE_CNT_EN
 ,output logic [CNT_W-1:0]     CycleCount
`endif
);

  localparam int unsigned LutDepth = 2 ** LUT_IDX_W;

  typedef enum logic [1:0] {
    Idle,
    Run,
    Halted
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] lut_q [LutDepth];
  logic            branchTaken;

  assign branchTaken = (state_q == Run) & BranchEn & ~AluZero & ~Halt;

  // Halt outranks a taken branch, which outranks the sequential increment.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    case (state_q)
      Idle, Halted: begin
        if (Start) begin
          state_d = Run;
          pc_d    = '0;
        end
      end
      Run: begin
        if (Halt) begin
          state_d = Halted;
          done_d  = 1'b1;
        end else if (branchTaken) begin
          pc_d = lut_q[LutIdx];
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = Idle;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= Idle;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  // The table is frozen while a program runs so targets cannot change under it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < LutDepth; i++) begin
        lut_q[i] <= '0;
      end
    end else if (LutWe && (state_q != Run)) begin
      lut_q[LutWaddr] <= LutWdata;
    end
  end

`ifdef CYCLE_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != Run) begin
      if (Start) begin
        cnt_d = '0;
      end
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CycleCount = cnt_q;
`endif

  assign PC          = pc_q;
  assign Running     = (state_q == Run);
  assign Done        = done_q;
  assign BranchTaken = branchTaken;

endmodule
